// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the fetch buffer stage.
package fetch_pkg;

    localparam int unsigned FETCH_ADDR_W  = 64;
    localparam int unsigned FETCH_INSTR_W = 32;
    localparam int unsigned FETCH_DEPTH   = 4;

    // One prefetched instruction with its PC and fall-through PC.
    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_ADDR_W-1:0]  pc_plus4;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch entry storage: circular buffer with wrap-around pointers and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = FETCH_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  fetch_entry_t            wdata_i,
    output fetch_entry_t            rdata_o,
    output logic [$clog2(DEPTH):0]  count_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == CNT_W'(0));
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // A push into a full buffer is only legal when the head leaves in the same cycle.
    assign do_pop  = pop_i & ~empty_o & ~flush_i;
    assign do_push = push_i & (~full_o | do_pop) & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; occupancy alone defines validity.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fetch_buffer_stage.sv
// Instruction fetch PC generation, redirect handling and prefetch buffering.
// Optional FETCH_BYPASS_EN lets a fetch reach the outputs in the same cycle when the buffer is empty.
module fetch_buffer_stage
    import fetch_pkg::*;
#(
    parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
    parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
    parameter int unsigned       DEPTH    = FETCH_DEPTH,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    branch_taken,
    input  logic [ADDR_W-1:0]       branch_target,
    output logic [ADDR_W-1:0]       imem_addr,
    input  logic [INSTR_W-1:0]      imem_rdata,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ADDR_W-1:0]       out_pc,
    output logic [ADDR_W-1:0]       out_pc_plus4,
    output logic [INSTR_W-1:0]      out_instr,
    output logic [$clog2(DEPTH):0]  count
);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pc_plus4;
    fetch_entry_t      push_entry, head_entry;
    logic              fifo_empty, fifo_full;
    logic              fifo_pop, fifo_push;
    logic              fetch_adv;
    logic              bypass_c;

    // Fall-through PC wraps silently at the top of the address space.
    assign pc_plus4  = fetch_pc_q + ADDR_W'(4);
    assign imem_addr = fetch_pc_q;

`ifdef FETCH_BYPASS_EN
    assign bypass_c = ~reset & fifo_empty & out_ready & ~branch_taken;
`else
    assign bypass_c = 1'b0;
`endif

    // A redirect kills any same-cycle push or pop and restarts from the target.
    assign fifo_pop  = ~fifo_empty & out_ready & ~branch_taken;
    assign fetch_adv = ~branch_taken & (~fifo_full | fifo_pop);
    assign fifo_push = fetch_adv & ~bypass_c;

    always_comb begin
        push_entry          = '0;
        push_entry.pc       = FETCH_ADDR_W'(fetch_pc_q);
        push_entry.pc_plus4 = FETCH_ADDR_W'(pc_plus4);
        push_entry.instr    = FETCH_INSTR_W'(imem_rdata);
    end

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        if (branch_taken) begin
            fetch_pc_d = branch_target;
        end else if (fetch_adv) begin
            fetch_pc_d = pc_plus4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q <= RESET_PC;
        end else begin
            fetch_pc_q <= fetch_pc_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .flush_i (branch_taken),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_entry),
        .rdata_o (head_entry),
        .count_o (count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    // Outputs read zero whenever nothing valid is presented.
    always_comb begin
        out_valid    = bypass_c | ~fifo_empty;
        out_pc       = '0;
        out_pc_plus4 = '0;
        out_instr    = '0;
        if (bypass_c) begin
            out_pc       = fetch_pc_q;
            out_pc_plus4 = pc_plus4;
            out_instr    = imem_rdata;
        end else if (!fifo_empty) begin
            out_pc       = ADDR_W'(head_entry.pc);
            out_pc_plus4 = ADDR_W'(head_entry.pc_plus4);
            out_instr    = INSTR_W'(head_entry.instr);
        end
    end

endmodule

// File: tb/tb_fetch_buffer_stage.sv
// Directed self-checking bench for fetch_buffer_stage with an expected-PC scoreboard.
module tb_fetch_buffer_stage;

    localparam logic [63:0] RST_PC = 64'h0;
`ifdef FETCH_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_pc;
    logic [63:0] out_pc_plus4;
    logic [31:0] out_instr;
    logic [2:0]  count;

    int checks   = 0;
    int failures = 0;
    int n_pops   = 0;
    int n0       = 0;
    logic [63:0] sb[$];
    logic [63:0] last_pop_pc = '0;

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hC0DE_0013;
    endfunction

    assign imem_rdata = instr_of(imem_addr);

    fetch_buffer_stage dut (
        .clk           (clk),
        .reset         (reset),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_pc        (out_pc),
        .out_pc_plus4  (out_pc_plus4),
        .out_instr     (out_instr),
        .count         (count)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sb_seed(input logic [63:0] pc);
        sb.delete();
        for (int i = 0; i < 16; i++) sb.push_back(pc + 64'(4 * i));
    endtask

    // Drive one cycle's inputs, then score any handshake seen before the next edge.
    task automatic drive(input logic rdy, input logic br, input logic [63:0] tgt);
        logic [63:0] e;
        out_ready     = rdy;
        branch_taken  = br;
        branch_target = tgt;
        #1;
        if (!reset && out_valid && out_ready && !branch_taken) begin
            check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_pc", out_pc, e);
                check("pop_pc_plus4", out_pc_plus4, e + 64'd4);
                check("pop_instr", 64'(out_instr), 64'(instr_of(e)));
                n_pops++;
                last_pop_pc = out_pc;
                if (sb.size() != 0) sb.push_back(sb[$] + 64'd4);
            end
        end
        if (br) sb_seed(tgt);
    endtask

    task automatic adv();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; out_ready = 1'b0; branch_taken = 1'b0; branch_target = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_valid", 64'(out_valid), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_pc", out_pc, 64'd0);
        check("rst_pc_plus4", out_pc_plus4, 64'd0);
        check("rst_instr", 64'(out_instr), 64'd0);
        check("rst_imem_addr", imem_addr, RST_PC);
        sb_seed(RST_PC);

        // Release with downstream ready: PCs 0,4,8 stream out.
        adv();
        reset = 1'b0;
        drive(1'b1, 1'b0, '0);
        check("lat_first_valid", 64'(out_valid), 64'(BYP));
        adv();
        repeat (3) begin drive(1'b1, 1'b0, '0); adv(); end
        check("stream_pops", 64'(n_pops), BYP ? 64'd4 : 64'd3);
        check("stream_last_pc", last_pop_pc, BYP ? 64'hC : 64'h8);

        // Back-pressure from reset: fill to DEPTH, stall at 0x10, drain with no loss.
        reset = 1'b1;
        drive(1'b0, 1'b0, '0);
        sb_seed(RST_PC);
        adv();
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, '0);
            check("fill_count", 64'(count), (k < 4) ? 64'(k) : 64'd4);
            if (k == 5) check("stall_imem_addr", imem_addr, 64'h10);
            adv();
        end
        n0 = n_pops;
        repeat (6) begin drive(1'b1, 1'b0, '0); adv(); end
        check("drain_pops", 64'(n_pops - n0), 64'd6);
        check("drain_last_pc", last_pop_pc, 64'h14);

        // Redirect with three entries buffered.
        drive(1'b0, 1'b1, 64'h200); adv();
        repeat (3) begin drive(1'b0, 1'b0, '0); adv(); end
        drive(1'b0, 1'b1, 64'h100);
        check("pre_br_count", 64'(count), 64'd3);
        adv();
        drive(1'b1, 1'b0, '0);
        check("post_br_count", 64'(count), 64'd0);
        check("post_br_valid", 64'(out_valid), 64'(BYP));
        adv();
        n0 = n_pops;
        repeat (3) begin drive(1'b1, 1'b0, '0); adv(); end
        check("br_last_pc", last_pop_pc, BYP ? 64'h10C : 64'h108);

        // Redirect coinciding with a handshake: the pop is dropped.
        drive(1'b0, 1'b0, '0); adv();
        drive(1'b1, 1'b1, 64'h300);
        check("hs_br_valid", 64'(out_valid), 64'd1);
        adv();
        drive(1'b1, 1'b0, '0);
        check("hs_br_count", 64'(count), 64'd0);
        adv();
        repeat (3) begin drive(1'b1, 1'b0, '0); adv(); end
        check("hs_last_pc", last_pop_pc, BYP ? 64'h30C : 64'h308);

        // PC wrap at the top of the address space.
        drive(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC); adv();
        drive(1'b1, 1'b0, '0);
        check("wrap_imem_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
        adv();
        drive(1'b1, 1'b0, '0);
        check("wrap_imem_zero", imem_addr, 64'h0);
        check("wrap_out_plus4", out_pc_plus4, BYP ? 64'h4 : 64'h0);
        adv();
        repeat (2) begin drive(1'b1, 1'b0, '0); adv(); end

        // Reset pulse with two entries buffered.
        drive(1'b0, 1'b1, 64'h400); adv();
        drive(1'b0, 1'b0, '0); adv();
        drive(1'b0, 1'b0, '0); adv();
        drive(1'b0, 1'b0, '0);
        check("pre_rst_count", 64'(count), 64'd2);
        check("pre_rst_valid", 64'(out_valid), 64'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_valid", 64'(out_valid), 64'd0);
        check("mid_rst_count", 64'(count), 64'd0);
        check("mid_rst_pc", out_pc, 64'd0);
        sb_seed(RST_PC);
        adv();
        adv();
        reset = 1'b0;
        drive(1'b1, 1'b0, '0);
        check("rel_lat0_valid", 64'(out_valid), 64'(BYP));
        check("rel_lat0_imem", imem_addr, RST_PC);
        adv();
        drive(1'b1, 1'b0, '0);
        check("rel_lat1_valid", 64'(out_valid), 64'd1);
        check("rel_lat1_pc", out_pc, BYP ? RST_PC + 64'd4 : RST_PC);
        adv();
        repeat (4) begin drive(1'b1, 1'b0, '0); adv(); end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_buffer_stage.md
FETCH_BUFFER_STAGE -- requirements
Module: fetch_buffer_stage

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, PC and address width.
REQ-002 SHALL have parameter INSTR_W, default 32, instruction width.
REQ-003 SHALL have parameter DEPTH, default 4, prefetch buffer entries; power of two, at least 2.
REQ-004 SHALL have parameter RESET_PC, default 0, PC loaded on reset.
REQ-005 SHALL have one clock; reset is asynchronous and active-high; ports are named clk and reset.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 branch_taken  input  1  redirect request.
REQ-009 branch_target  input  ADDR_W  redirect PC.
REQ-010 imem_addr  output  ADDR_W  instruction memory address, equal to fetch PC.
REQ-011 imem_rdata  input  INSTR_W  instruction at imem_addr, combinational, same cycle.
REQ-012 out_valid  output  1  head entry valid.
REQ-013 out_ready  input  1  downstream accepts head.
REQ-014 out_pc, out_pc_plus4  output  ADDR_W each  head PC and head PC+4.
REQ-015 out_instr  output  INSTR_W  head instruction.
REQ-016 count  output  $clog2(DEPTH)+1  current occupancy.

Function
REQ-017 SHALL hold fetch_pc; each cycle with buffer not full and no branch_taken, push {fetch_pc, fetch_pc+4, imem_rdata} and set fetch_pc to fetch_pc+4.
REQ-018 Pop SHALL occur on the clk edge where out_valid and out_ready are both 1; outputs show the head entry, in FIFO order.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; a push is allowed when full only if a pop occurs in the same cycle.
REQ-020 Full (count==DEPTH) SHALL stall fetch_pc; imem_addr holds its value.
REQ-021 Read and write pointers SHALL wrap modulo DEPTH.
REQ-022 PC+4 SHALL wrap modulo 2^ADDR_W with no flag.
REQ-023 On branch_taken, the next edge SHALL discard all entries (count=0), drop any same-cycle push or pop, and load fetch_pc with branch_target; branch_taken has priority over all other events.
REQ-024 out_valid SHALL be 0 in the cycle after a redirect, except as allowed by REQ-029.
REQ-025 Minimum latency from an address on imem_addr to out_valid SHALL be 1 cycle.

Reset
REQ-026 While reset is asserted: fetch_pc=RESET_PC, pointers=0, count=0, out_valid=0; out_pc, out_pc_plus4 and out_instr read 0.
REQ-027 Reset mid-operation SHALL discard all buffered entries immediately; the first push after deassertion uses RESET_PC.

Configuration
REQ-028 Macro FETCH_BYPASS_EN SHALL select the bypass feature.
REQ-029 With FETCH_BYPASS_EN defined: when count==0, out_ready=1 and there is no branch_taken, the current fetch SHALL drive the outputs combinationally with out_valid=1, and SHALL be consumed without being written to the buffer (0-cycle latency).
REQ-030 Without FETCH_BYPASS_EN, behaviour SHALL be exactly as in REQ-025.

Structure
REQ-031 Package fetch_pkg SHALL hold fetch_entry_t (pc, pc_plus4, instr) and a default DEPTH constant.
REQ-032 Sub-module fetch_fifo (entry storage, pointers, count) SHALL be instantiated once; PC logic and redirect logic stay in the top module.

Verification
REQ-033 Reset release, out_ready=1: out_pc sequence SHALL be 0x0, 0x4, 0x8 on successive cycles; out_pc_plus4 SHALL be 0x4, 0x8, 0xC.
REQ-034 out_ready=0 for 6 cycles: count SHALL reach 4 and stick there, imem_addr SHALL hold 0x10, and no entry SHALL be lost after release.
REQ-035 branch_taken with target 0x100 while count=3: the next edge SHALL give count=0, and the first popped out_pc SHALL be 0x100.
REQ-036 branch_taken together with out_valid&out_ready: the pop SHALL be ignored, and the next out_pc SHALL be the target.
REQ-037 fetch_pc at 0xFFFF_FFFF_FFFF_FFFC: out_pc_plus4 SHALL be 0x0, and the next fetch SHALL use 0x0.
REQ-038 reset pulsed with count=2: out_valid SHALL drop at once; after release, the first out_pc SHALL be RESET_PC; run with and without FETCH_BYPASS_EN, checking latency 0 and 1 respectively.
